crc7_frame_rx: RTL and testbench

Serial receive-side checker for CRC-7 (x^7 + x^3 + 1) protected command frames (SD/MMC command layout by default). Takes a bit-enabled serial line, detects the start bit, shifts in payload and the trailing 7-bit CRC, recomputes CRC-7 over the payload, and reports the decoded frame with CRC and end-bit status. It is the receive-side counterpart of the serial CRC-7 generator used on the transmit path and sits behind the line sampler in the command-channel receiver.

---
 rtl/crc7_frame_rx_if.sv | 48 ++++
 rtl/crc7_frame_rx.sv | 135 +++++++++++++
 tb/tb_crc7_frame_rx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/crc7_frame_rx_if.sv
// Command-line receive bundle between the line sampler and crc7_frame_rx.
// err_cnt_o exists only when CRC7_RX_ERRCNT_EN is defined.
interface crc7_frame_rx_if #(
    parameter int PAYLOAD_W = 40
);
    logic                 bit_en;
    logic                 sda_i;
    logic                 busy_o;
    logic                 frame_valid_o;
    logic                 crc_ok_o;
    logic                 end_ok_o;
    logic [PAYLOAD_W-1:0] payload_o;
    logic [6:0]           rx_crc_o;
`ifdef CRC7_RX_ERRCNT_EN
    logic [7:0]           err_cnt_o;
`endif

    // Line sampler side: drives the qualified serial bit, observes decoded frames.
    modport master (
        output bit_en,
        output sda_i,
        input  busy_o,
        input  frame_valid_o,
        input  crc_ok_o,
        input  end_ok_o,
        input  payload_o,
        input  rx_crc_o
`ifdef CRC7_RX_ERRCNT_EN
        ,
        input  err_cnt_o
`endif
    );

    modport slave (
        input  bit_en,
        input  sda_i,
        output busy_o,
        output frame_valid_o,
        output crc_ok_o,
        output end_ok_o,
        output payload_o,
        output rx_crc_o
`ifdef CRC7_RX_ERRCNT_EN
        ,
        output err_cnt_o
`endif
    );
endinterface

// File: rtl/crc7_frame_rx.sv
// Serial CRC-7 (x^7+x^3+1) command-frame receiver/checker: start bit, payload, CRC field, end bit.
// Optional error counter output err_cnt_o is built when CRC7_RX_ERRCNT_EN is defined.
module crc7_frame_rx #(
    parameter int PAYLOAD_W = 40
) (
    input  logic           clk,
    input  logic           rst,
    crc7_frame_rx_if.slave rx
);

    // The counter must also reach 6 in the CRC field, which matters for tiny PAYLOAD_W.
    localparam int CNT_W_RAW = $clog2(PAYLOAD_W + 1);
    localparam int CNT_W     = (CNT_W_RAW < 3) ? 3 : CNT_W_RAW;

    localparam logic [CNT_W-1:0] LAST_PAY = CNT_W'(PAYLOAD_W - 1);
    localparam logic [CNT_W-1:0] LAST_CRC = CNT_W'(6);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_CRC     = 2'd2;
    localparam logic [1:0] S_END     = 2'd3;

    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [6:0]           crc;
    logic [PAYLOAD_W-1:0] pay_sr;
    logic [6:0]           crc_sr;

    logic                 frame_valid;
    logic                 crc_ok;
    logic                 end_ok;
    logic [PAYLOAD_W-1:0] payload;
    logic [6:0]           rx_crc;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic inv;
        inv = b ^ c[6];
        return {c[5], c[4], c[3], c[2] ^ inv, c[1], c[0], inv};
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Shift registers are pure datapath: they are always rewritten before being published.
    always_ff @(posedge clk) begin
        if (rx.bit_en) begin
            case (state)
                S_IDLE:    pay_sr <= {{(PAYLOAD_W-1){1'b0}}, rx.sda_i};
                S_PAYLOAD: pay_sr <= {pay_sr[PAYLOAD_W-2:0], rx.sda_i};
                S_CRC:     crc_sr <= {crc_sr[5:0], rx.sda_i};
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            crc         <= '0;
            frame_valid <= 1'b0;
            crc_ok      <= 1'b0;
            end_ok      <= 1'b0;
            payload     <= '0;
            rx_crc      <= '0;
        end else begin
            frame_valid <= 1'b0;
            if (rx.bit_en) begin
                case (state)
                    S_IDLE: begin
                        // The CRC restarts from zero with the start bit of each frame.
                        if (!rx.sda_i) begin
                            state <= S_PAYLOAD;
                            cnt   <= CNT_W'(1);
                            crc   <= crc7_step(7'h00, rx.sda_i);
                        end
                    end
                    S_PAYLOAD: begin
                        crc <= crc7_step(crc, rx.sda_i);
                        if (cnt == LAST_PAY) begin
                            state <= S_CRC;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_CRC: begin
                        if (cnt == LAST_CRC) begin
                            state <= S_END;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_END: begin
                        frame_valid <= 1'b1;
                        payload     <= pay_sr;
                        rx_crc      <= crc_sr;
                        crc_ok      <= (crc_sr == crc);
                        end_ok      <= rx.sda_i;
                        state       <= S_IDLE;
                        cnt         <= '0;
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef CRC7_RX_ERRCNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (rx.bit_en && (state == S_END) && ((crc_sr != crc) || !rx.sda_i)) begin
            err_cnt <= sat_inc8(err_cnt);
        end
    end

    assign rx.err_cnt_o = err_cnt;
`endif

    assign rx.busy_o        = (state != S_IDLE);
    assign rx.frame_valid_o = frame_valid;
    assign rx.crc_ok_o      = crc_ok;
    assign rx.end_ok_o      = end_ok;
    assign rx.payload_o     = payload;
    assign rx.rx_crc_o      = rx_crc;

endmodule

// File: tb/tb_crc7_frame_rx.sv
// Scoreboard bench for crc7_frame_rx: frames pushed by the driver, popped and compared by a monitor.
module tb_crc7_frame_rx;

    localparam int PW = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crc7_frame_rx_if #(.PAYLOAD_W(PW)) bus ();

    crc7_frame_rx #(.PAYLOAD_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus)
    );

    typedef struct {
        logic [PW-1:0] pay;
        logic [6:0]    crc;
        logic          crc_ok;
        logic          end_ok;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   exp_err = 0;

    // Reference CRC: remainder of payload * x^7 divided by x^7 + x^3 + 1 (0x89).
    function automatic logic [6:0] ref_crc(input logic [PW-1:0] p);
        logic [PW+6:0] r;
        r = {p, 7'b0};
        for (int i = PW + 6; i >= 7; i--) begin
            if (r[i]) r[i-:8] = r[i-:8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (rst) begin
            exp_err = 0;
        end else if (bus.frame_valid_o) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: got frame_valid_o=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("payload", 64'(bus.payload_o), 64'(e.pay));
                chk("rx_crc",  64'(bus.rx_crc_o),  64'(e.crc));
                chk("crc_ok",  64'(bus.crc_ok_o),  64'(e.crc_ok));
                chk("end_ok",  64'(bus.end_ok_o),  64'(e.end_ok));
                chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
`ifdef CRC7_RX_ERRCNT_EN
                if (!(e.crc_ok && e.end_ok) && exp_err < 255) exp_err++;
                chk("err_cnt", 64'(bus.err_cnt_o), 64'(exp_err));
`endif
            end
        end
    end

    // mode 0: bit_en high; mode 1: 1/0 toggling plus random 3-cycle stalls; mode 2: random stalls.
    task automatic send_frame(input logic [PW-1:0] pay, input logic [6:0] crc, input logic endb,
                              input int mode, input bit chk_busy);
        logic [PW+7:0] fr;
        exp_t          e;
        int            start_cyc;
        int            nst;
        fr       = {pay, crc, endb};
        e.pay    = pay;
        e.crc    = crc;
        e.crc_ok = (crc == ref_crc(pay));
        e.end_ok = endb;
        e.cyc    = 0;
        start_cyc = 0;
        for (int k = 0; k < PW + 8; k++) begin
            if (k > 0 && mode != 0) begin
                if (mode == 1) nst = 1 + (($urandom_range(0, 3) == 0) ? 3 : 0);
                else           nst = int'($urandom_range(0, 2));
                repeat (nst) begin
                    @(negedge clk);
                    if (chk_busy) chk("busy_stall", 64'(bus.busy_o), 64'd1);
                    bus.bit_en = 1'b0;
                    bus.sda_i  = 1'($urandom);
                end
            end
            @(negedge clk);
            if (k > 0 && chk_busy) chk("busy", 64'(bus.busy_o), 64'd1);
            if (k == 0) start_cyc = cyc;
            if (k == PW + 7) begin
                e.cyc = (mode == 0) ? start_cyc + PW + 8 : cyc + 1;
                sb.push_back(e);
            end
            bus.bit_en = 1'b1;
            bus.sda_i  = fr[PW+7-k];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) chk("busy_idle", 64'(bus.busy_o), 64'd0);
            bus.bit_en = 1'($urandom);
            bus.sda_i  = 1'b1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},    64'(bus.busy_o),        64'd0);
        chk({tag, "_valid"},   64'(bus.frame_valid_o), 64'd0);
        chk({tag, "_crc_ok"},  64'(bus.crc_ok_o),      64'd0);
        chk({tag, "_end_ok"},  64'(bus.end_ok_o),      64'd0);
        chk({tag, "_payload"}, 64'(bus.payload_o),     64'd0);
        chk({tag, "_rx_crc"},  64'(bus.rx_crc_o),      64'd0);
`ifdef CRC7_RX_ERRCNT_EN
        chk({tag, "_err_cnt"}, 64'(bus.err_cnt_o),     64'd0);
`endif
    endtask

    task automatic apply_rst(input string tag);
        @(negedge clk);
        rst        = 1'b1;
        bus.bit_en = 1'b0;
        bus.sda_i  = 1'b1;
        @(negedge clk);
        check_zero(tag);
        rst = 1'b0;
    endtask

    localparam logic [PW-1:0] CMD0  = 40'h40_0000_0000;
    localparam logic [PW-1:0] CMD8  = 40'h48_0000_01AA;
    localparam logic [PW-1:0] CMD55 = 40'h77_0000_0000;

    initial begin
        logic [PW-1:0] p;
        logic [6:0]    c;
        logic          eb;
        logic [PW+7:0] fr;

        rst        = 1'b1;
        bus.bit_en = 1'b0;
        bus.sda_i  = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        idle(2);

        send_frame(CMD0, 7'h4A, 1'b1, 0, 1'b1);
        idle(3);
        send_frame(CMD8,  7'h43, 1'b1, 0, 1'b0);
        send_frame(CMD55, 7'h32, 1'b1, 0, 1'b0);
        idle(3);
        send_frame(CMD0, 7'h4B, 1'b1, 0, 1'b0);
        idle(2);
        send_frame(CMD0, 7'h4A, 1'b0, 0, 1'b0);
        idle(2);
        send_frame(CMD0, 7'h4A, 1'b1, 1, 1'b1);
        idle(2);

        // Abort a frame after payload bit 20; nothing is queued for it.
        fr = {CMD0, 7'h4A, 1'b1};
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            bus.bit_en = 1'b1;
            bus.sda_i  = fr[PW+7-k];
        end
        apply_rst("abort");
        idle(2);
        send_frame(CMD8, 7'h43, 1'b1, 0, 1'b0);
        idle(2);

        for (int n = 0; n < 20; n++) begin
            p = PW'({$urandom, $urandom});
            p[PW-1] = 1'b0;
            c = ref_crc(p);
            if ($urandom_range(0, 1) == 0) c = c ^ (7'h01 << $urandom_range(0, 6));
            eb = ($urandom_range(0, 4) != 0);
            send_frame(p, c, eb, 2, 1'b1);
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 3)));
        end

`ifdef CRC7_RX_ERRCNT_EN
        for (int n = 0; n < 258; n++) send_frame(CMD0, 7'h4B, 1'b1, 0, 1'b0);
`endif

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d frames outstanding expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
